hdmi_axis_pattern_tx: RTL
=========================

Name: hdmi_axis_pattern_tx

Overview:
AXI4-Stream master that generates complete video frames of test-pattern pixels for the HDMI output path. It is the transmit-side counterpart of the 24-bit line-buffer AXIS slave. Output is one pixel per beat, TUSER on the first pixel of a frame and TLAST on the last pixel of every line. Used to drive the line FIFO and HDMI pipeline with no DMA present, and as a stimulus source in system simulation.

Parameters:
C_M_AXIS_TDATA_WIDTH, 24, pixel width; fixed {R[23:16],G[15:8],B[7:0]}; only 24 supported
H_ACTIVE, 1280, pixels per line; must be a multiple of 8 and at least 8
V_ACTIVE, 720, lines per frame; at least 1
LINE_GAP, 4, idle cycles (TVALID=0) after each line; 0 means back-to-back lines

Ports:
M_AXIS_ACLK  in  1  single clock
M_AXIS_ARESET  in  1  asynchronous, active-high reset
en  in  1  run enable; level-sensitive
pattern_sel  in  2  0 colour bars, 1 ramp, 2 solid, 3 checkerboard
solid_rgb  in  24  colour used when pattern_sel=2
M_AXIS_TDATA  out  24  pixel
M_AXIS_TVALID  out  1  beat valid
M_AXIS_TREADY  in  1  downstream ready
M_AXIS_TLAST  out  1  last pixel of line
M_AXIS_TUSER  out  1  first pixel of frame
frame_done  out  1  one-cycle pulse, same edge as the last beat's handshake
busy  out  1  high when state is not IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; x=0, y=0, bar counters 0. Reset mid-frame aborts immediately; no partial-frame recovery.
- Beat transfer occurs on a rising edge with TVALID && TREADY.
- While TVALID && !TREADY, TDATA, TLAST and TUSER are held stable. TVALID never drops without a transfer.
- States:
  - IDLE: en=1 sampled at edge N loads the frame. At edge N+1 the state is ACTIVE, TVALID=1, pixel (0,0) is presented, TUSER=1.
  - ACTIVE: presents pixel (x,y). On transfer, x increments. The beat with x=H_ACTIVE-1 carries TLAST=1. On that beat's transfer, x wraps to 0 and y increments (or wraps at V_ACTIVE-1). The state then moves to GAP if LINE_GAP>0, otherwise stays ACTIVE with the next pixel valid the following cycle.
  - GAP: TVALID=0 for exactly LINE_GAP cycles, then returns to ACTIVE.
- Frame end: the transfer of pixel (H_ACTIVE-1, V_ACTIVE-1) pulses frame_done.
  - en=1 at that edge: the next frame follows after the gap.
  - en=0 at that edge: go to IDLE after the gap, or directly to IDLE if LINE_GAP=0.
- en deasserted mid-frame has no effect until frame end; frames are never truncated.
- pattern_sel and solid_rgb are latched when a frame starts and held for the whole frame.
- TUSER=1 only for pixel (0,0); TLAST=1 only for x=H_ACTIVE-1.
- Patterns, with bar width W=H_ACTIVE/8 tracked by a counter (no divider):
  - Bars, indices 0..7: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Ramp: R=x[7:0], G=y[7:0], B=(x+y) mod 256.
  - Solid: the latched solid_rgb.
  - Checker: FFFFFF when x[5]^y[5], else 000000.
- TDATA is registered, so the pixel for the next position is computed one cycle ahead. No combinational path from TREADY to TDATA.

Decomposition:
- Package hdmi_video_pkg holds:
  - pattern code constants PAT_BARS/PAT_RAMP/PAT_SOLID/PAT_CHECK
  - the 8 bar-colour constants
  - the default H_ACTIVE/V_ACTIVE
  - the state encoding IDLE/ACTIVE/GAP
- One sub-module, hdmi_pattern_pixel: combinational map from (x, y, bar_idx, sel, solid) to 24-bit RGB. The top level holds the FSM, counters and output registers.

Test Plan (H_ACTIVE=16, V_ACTIVE=4, LINE_GAP=2 unless stated):
- TREADY=1, en pulsed 1 cycle, sel=0: 64 beats and one frame.
  - TUSER only on beat 0; TLAST on beats 15, 31, 47, 63.
  - TDATA line 0 = FFFFFF×2, FFFF00×2, …, 000000×2.
  - 2-cycle TVALID gaps after each line.
  - frame_done once; then IDLE, busy=0.
- Random TREADY (50%), sel=1: TDATA/TLAST/TUSER stable across every stall. Beat (x=5, y=3) = R=05, G=03, B=08. Count is exactly 64.
- en held high, sel=2, solid_rgb=123456, switched to ABCDEF mid-frame 1: frame 1 is all 123456, frame 2 is all ABCDEF; TUSER on beat 0 of each frame.
- LINE_GAP=0, TREADY=1: 64 consecutive valid beats with no bubble; TLAST at every 16th beat.
- M_AXIS_ARESET asserted at beat 20 during a stall: outputs 0 immediately. After release with en=1, the frame restarts at (0,0) with TUSER=1.
- sel=3, H_ACTIVE=64, V_ACTIVE=2, LINE_GAP=0: pixels 0–31 are 000000, pixels 32–63 are FFFFFF.

Source files
------------

// File: rtl/hdmi_video_pkg.sv
// Shared video constants for the HDMI test-pattern path: pattern codes,
// bar colours, default raster size, FSM encoding and the pixel-position record.
package hdmi_video_pkg;

  localparam int H_ACTIVE_DEF = 1280;
  localparam int V_ACTIVE_DEF = 720;
  localparam int CNT_W        = 16;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_RAMP  = 2'd1;
  localparam logic [1:0] PAT_SOLID = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_e;

  // bar_cnt/bar_idx walk alongside x so no divide by H_ACTIVE/8 is needed
  typedef struct packed {
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic [CNT_W-1:0] bar_cnt;
    logic [2:0]       bar_idx;
  } pos_t;

  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_rgb = BAR_WHITE;
      3'd1:    bar_rgb = BAR_YELLOW;
      3'd2:    bar_rgb = BAR_CYAN;
      3'd3:    bar_rgb = BAR_GREEN;
      3'd4:    bar_rgb = BAR_MAGENTA;
      3'd5:    bar_rgb = BAR_RED;
      3'd6:    bar_rgb = BAR_BLUE;
      default: bar_rgb = BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/hdmi_pattern_pixel.sv
// Combinational pattern generator: maps a raster position and pattern
// selection to one 24-bit {R,G,B} pixel.
module hdmi_pattern_pixel
  import hdmi_video_pkg::*;
(
  input  logic [7:0]  i_x,
  input  logic [7:0]  i_y,
  input  logic [2:0]  i_bar_idx,
  input  logic [1:0]  i_sel,
  input  logic [23:0] i_solid,
  output logic [23:0] o_rgb
);

  logic [7:0] w_sum;
  assign w_sum = i_x + i_y;

  always_comb begin
    o_rgb = '0;
    case (i_sel)
      PAT_BARS:  o_rgb = bar_rgb(i_bar_idx);
      PAT_RAMP:  o_rgb = {i_x, i_y, w_sum};
      PAT_SOLID: o_rgb = i_solid;
      PAT_CHECK: o_rgb = (i_x[5] ^ i_y[5]) ? 24'hFFFFFF : 24'h000000;
      default:   o_rgb = '0;
    endcase
  end

endmodule

// File: rtl/hdmi_axis_pattern_tx.sv
// AXI4-Stream video master producing full test-pattern frames, one pixel per
// beat, TUSER on pixel (0,0), TLAST at end of line, optional idle gap per line.
module hdmi_axis_pattern_tx
  import hdmi_video_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = 24,
  parameter int H_ACTIVE             = H_ACTIVE_DEF,
  parameter int V_ACTIVE             = V_ACTIVE_DEF,
  parameter int LINE_GAP             = 4
) (
  input  logic                            M_AXIS_ACLK,
  input  logic                            M_AXIS_ARESET,
  input  logic                            en,
  input  logic [1:0]                      pattern_sel,
  input  logic [23:0]                     solid_rgb,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                            M_AXIS_TVALID,
  input  logic                            M_AXIS_TREADY,
  output logic                            M_AXIS_TLAST,
  output logic                            M_AXIS_TUSER,
  output logic                            frame_done,
  output logic                            busy
);

  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(LINE_GAP - 1);

  state_e                          r_state, w_state_nxt;
  pos_t                            r_pos, w_pos_nxt;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] r_tdata;
  logic [23:0]                     w_pix;
  logic [1:0]                      r_sel, w_sel;
  logic [23:0]                     r_solid, w_solid;
  logic                            r_stop;
  logic                            r_frame_done;
  logic [CNT_W-1:0]                r_gap_cnt;

  logic w_xfer, w_last_x, w_last_y, w_line_end, w_frame_end;
  logic w_start, w_new_frame, w_load;

  assign w_xfer      = M_AXIS_TVALID & M_AXIS_TREADY;
  assign w_last_x    = (r_pos.x == X_LAST);
  assign w_last_y    = (r_pos.y == Y_LAST);
  assign w_line_end  = w_xfer & w_last_x;
  assign w_frame_end = w_line_end & w_last_y;
  assign w_start     = (r_state == IDLE) & en;
  assign w_load      = w_start | w_xfer;

  // A new frame picks up pattern_sel/solid_rgb directly so its first pixel
  // already uses the settings that get latched for the rest of the frame.
  assign w_new_frame = w_start | (w_frame_end & en);
  assign w_sel       = w_new_frame ? pattern_sel : r_sel;
  assign w_solid     = w_new_frame ? solid_rgb   : r_solid;

  always_comb begin
    w_pos_nxt = r_pos;
    if (w_start) begin
      w_pos_nxt = '0;
    end else if (w_last_x) begin
      w_pos_nxt   = '0;
      w_pos_nxt.y = w_last_y ? '0 : r_pos.y + 1'b1;
    end else begin
      w_pos_nxt.x = r_pos.x + 1'b1;
      if (r_pos.bar_cnt == BAR_LAST) begin
        w_pos_nxt.bar_cnt = '0;
        w_pos_nxt.bar_idx = r_pos.bar_idx + 1'b1;
      end else begin
        w_pos_nxt.bar_cnt = r_pos.bar_cnt + 1'b1;
      end
    end
  end

  // Pixel for the next position, registered on load so TDATA never sees TREADY
  hdmi_pattern_pixel u_pixel (
    .i_x       (w_pos_nxt.x[7:0]),
    .i_y       (w_pos_nxt.y[7:0]),
    .i_bar_idx (w_pos_nxt.bar_idx),
    .i_sel     (w_sel),
    .i_solid   (w_solid),
    .o_rgb     (w_pix)
  );

  always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
    if (M_AXIS_ARESET) begin
      r_pos        <= '0;
      r_tdata      <= '0;
      r_sel        <= '0;
      r_solid      <= '0;
      r_stop       <= 1'b0;
      r_frame_done <= 1'b0;
      r_gap_cnt    <= '0;
    end else begin
      r_frame_done <= w_frame_end;
      if (w_load) begin
        r_pos   <= w_pos_nxt;
        r_tdata <= w_pix;
      end
      if (w_new_frame) begin
        r_sel   <= pattern_sel;
        r_solid <= solid_rgb;
      end
      if (w_line_end) r_stop <= w_last_y & ~en;
      r_gap_cnt <= (r_state == GAP) ? r_gap_cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
    if (M_AXIS_ARESET) r_state <= IDLE;
    else               r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (en) w_state_nxt = ACTIVE;
      ACTIVE: begin
        if (w_line_end) begin
          if (LINE_GAP > 0)           w_state_nxt = GAP;
          else if (w_last_y && !en)   w_state_nxt = IDLE;
        end
      end
      GAP:    if (r_gap_cnt == GAP_LAST) w_state_nxt = r_stop ? IDLE : ACTIVE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    M_AXIS_TVALID = (r_state == ACTIVE);
    M_AXIS_TLAST  = M_AXIS_TVALID & w_last_x;
    M_AXIS_TUSER  = M_AXIS_TVALID & (r_pos.x == '0) & (r_pos.y == '0);
    busy          = (r_state != IDLE);
  end

  assign M_AXIS_TDATA = r_tdata;
  assign frame_done   = r_frame_done;

endmodule
